// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and sizing for the EX-stage multiply/divide controller.
// The iteration count is the operand width: one bit is resolved per CALC cycle.
package ex_muldiv_pkg;

   localparam int DATA_W = 32;
   localparam int ITER_N = 32;
   localparam int CNT_W  = 5;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CALC  = 2'b01,
      ST_FIXUP = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   function automatic logic op_is_div(input op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input op_e op);
      return op[0];
   endfunction

   // Magnitude of a possibly-signed operand; 0x80000000 maps to itself, which is
   // the correct unsigned magnitude.
   function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                 input logic is_signed);
      return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
// Both modes share the accumulator layout {upper half, lower half}.
module muldiv_step
   import ex_muldiv_pkg::*;
(
   input  logic [2*DATA_W-1:0] acc,
   input  logic [DATA_W-1:0]   operand,
   input  logic                is_div,
   output logic [2*DATA_W-1:0] acc_next
);

   logic [DATA_W:0]   add_sum;
   logic [DATA_W:0]   rem_shift;
   logic [DATA_W-1:0] sub_diff;
   logic              sub_ok;

   always_comb begin
      // Multiply: multiplier sits in the low half and is consumed LSB first.
      add_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, operand} : '0);
      // Divide: the 33-bit shifted remainder never exceeds 2*divisor, so the
      // difference fits in 32 bits whenever the subtraction is taken.
      rem_shift = acc[2*DATA_W-1:DATA_W-1];
      sub_ok    = (rem_shift >= {1'b0, operand});
      sub_diff  = rem_shift[DATA_W-1:0] - operand;
      if (is_div) begin
         if (sub_ok)
            acc_next = {sub_diff, acc[DATA_W-2:0], 1'b1};
         else
            acc_next = {rem_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
      end else begin
         acc_next = {add_sum, acc[DATA_W-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit that stalls the EX stage while it runs.
// Operates on magnitudes and applies sign correction in a single FIXUP cycle.
module ex_muldiv_ctrl
   import ex_muldiv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   input  logic [1:0]        op_code,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              flush,
   output logic              ex_stall,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   state_e              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg;
   logic [2*DATA_W-1:0] acc_reg;
   logic [2*DATA_W-1:0] step_acc;
   logic [DATA_W-1:0]   divisor_reg;
   logic                div_reg;
   logic                neg_a_reg;
   logic                neg_b_reg;
   logic                dbz_reg;
   logic [DATA_W-1:0]   hi_reg, lo_reg;

   op_e                 in_op;
   logic                accept;
   logic                in_div;
   logic                in_signed;
   logic                in_dbz;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quot_fix;
   logic [DATA_W-1:0]   rem_fix;

   assign in_op     = op_e'(op_code);
   assign in_div    = op_is_div(in_op);
   assign in_signed = op_is_signed(in_op);
   assign in_dbz    = in_div && (op_b == '0);
   assign accept    = (state_reg == ST_IDLE) && op_valid && !flush;

   muldiv_step u_step (
      .acc      (acc_reg),
      .operand  (divisor_reg),
      .is_div   (div_reg),
      .acc_next (step_acc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (accept) state_next = in_dbz ? ST_DONE : ST_CALC;
         ST_CALC:  if (cnt_reg == '0) state_next = ST_FIXUP;
         ST_FIXUP: state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      if (flush)
         state_next = ST_IDLE;
   end

   // Unsigned ops never set the sign flags, so the fixup is a pass-through.
   always_comb begin
      prod_fix = (neg_a_reg ^ neg_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
      quot_fix = (neg_a_reg ^ neg_b_reg) ? (~acc_reg[DATA_W-1:0] + 1'b1)
                                         : acc_reg[DATA_W-1:0];
      rem_fix  = neg_a_reg ? (~acc_reg[2*DATA_W-1:DATA_W] + 1'b1)
                           : acc_reg[2*DATA_W-1:DATA_W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg     <= '0;
         acc_reg     <= '0;
         divisor_reg <= '0;
         div_reg     <= 1'b0;
         neg_a_reg   <= 1'b0;
         neg_b_reg   <= 1'b0;
         dbz_reg     <= 1'b0;
         hi_reg      <= '0;
         lo_reg      <= '0;
      end else if (accept) begin
         cnt_reg     <= CNT_W'(ITER_N - 1);
         acc_reg     <= {{DATA_W{1'b0}}, abs_val(op_a, in_signed)};
         divisor_reg <= abs_val(op_b, in_signed);
         div_reg     <= in_div;
         neg_a_reg   <= in_signed && op_a[DATA_W-1];
         neg_b_reg   <= in_signed && op_b[DATA_W-1];
         dbz_reg     <= in_dbz;
         if (in_dbz) begin
            hi_reg <= op_a;
            lo_reg <= '1;
         end
      end else if (!flush && state_reg == ST_CALC) begin
         acc_reg <= step_acc;
         if (cnt_reg != '0)
            cnt_reg <= cnt_reg - 1'b1;
      end else if (!flush && state_reg == ST_FIXUP) begin
         if (div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
         end else begin
            hi_reg <= prod_fix[2*DATA_W-1:DATA_W];
            lo_reg <= prod_fix[DATA_W-1:0];
         end
      end
   end

   assign busy        = (state_reg != ST_IDLE);
   assign done        = (state_reg == ST_DONE) && !flush;
   assign div_by_zero = done && dbz_reg;
   assign ex_stall    = !rst && (accept || state_reg == ST_CALC || state_reg == ST_FIXUP);
   assign hi          = hi_reg;
   assign lo          = lo_reg;

endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: op_valid  in  1  EX stage holds a mul/div instruction.
REQ-004 SHALL have ports: op_code  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have ports: op_a, op_b  in  32 each  operands (RegDataA / RegDataB).
REQ-006 SHALL have ports: flush  in  1  cancel in-flight operation.
REQ-007 SHALL have ports: ex_stall  out  1  hold IF/ID/EX pipeline registers.
REQ-008 SHALL have ports: busy  out  1  state != IDLE.
REQ-009 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: div_by_zero  out  1  pulse with done for divide by zero.
REQ-011 SHALL have ports: hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM IDLE, CALC, FIXUP, DONE.
REQ-013 IDLE and op_valid and not flush SHALL accept: latch |op_a|, |op_b|, the operand signs (signed ops only) and op_code; load 5-bit counter = 31; go to CALC.
REQ-014 SHALL exempt divide by zero: on accept with op_b==0 for DIVU/DIV, SHALL go directly to DONE and write hi=op_a, lo=0xFFFFFFFF at the end of the accept cycle.
REQ-015 CALC SHALL perform one shift-add (mul) or restoring shift-subtract (div) step per cycle, decrement the counter, and go to FIXUP after the step at counter 0 (32 steps).
REQ-016 FIXUP SHALL negate the 64-bit product when operand signs differ (MULT) and, for DIV, negate the quotient when signs differ and the remainder when the dividend is negative. It SHALL write hi/lo (mul: hi=product[63:32], lo=product[31:0]; div: hi=remainder, lo=quotient) and go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, then go to IDLE. No accept SHALL occur in DONE.
REQ-018 ex_stall SHALL be (IDLE and op_valid and not flush) or CALC or FIXUP. It SHALL be 0 in DONE, so that the pipeline advances on the done cycle.
REQ-019 Latency: accept at cycle 0; CALC at cycles 1-32; FIXUP at cycle 33; DONE at cycle 34. ex_stall SHALL be high for exactly 34 cycles. Divide by zero SHALL stall 1 cycle, with done at cycle 1.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0. No trap.
REQ-021 flush SHALL return the FSM to IDLE on the next edge from any state. hi/lo SHALL be unchanged unless the FIXUP write has already occurred. flush SHALL suppress done and div_by_zero.
REQ-022 flush and op_valid together in IDLE: flush SHALL win, no accept.
REQ-023 Operand inputs SHALL be ignored outside the accept cycle.

Reset
REQ-024 rst SHALL immediately force: state IDLE; hi=0, lo=0; counter 0; busy=0, done=0, div_by_zero=0.
REQ-025 ex_stall SHALL be 0 while rst is high.
REQ-026 Reset mid-CALC SHALL abandon the operation with no done pulse after release.

Structure
REQ-027 Package ex_muldiv_pkg SHALL hold: op_code encodings, FSM state encoding, data width 32, and iteration count 32.
REQ-028 Per-cycle iteration SHALL be a single sub-module muldiv_step (combinational: 64-bit accumulator, 32-bit operand, mode in; next accumulator out). FSM, counter, sign fixup and HI/LO SHALL be in ex_muldiv_ctrl.

Verification
REQ-029 Bench SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF -> ex_stall high 34 cycles, done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 Bench SHALL cover: MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 Bench SHALL cover: DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-032 Bench SHALL cover: DIVU 5/0 -> ex_stall high 1 cycle, done and div_by_zero at cycle 1, hi=5, lo=0xFFFFFFFF.
REQ-033 Bench SHALL cover: flush at cycle 10 of CALC -> IDLE next cycle, ex_stall low, no done, hi/lo unchanged; a new op_valid the following cycle is accepted.
REQ-034 Bench SHALL cover: rst asserted mid-cycle during CALC -> hi=lo=0, busy=0, ex_stall=0 before the next edge; no done after release.
